// File: rtl/vector_rf_write_arbiter_pkg.sv
// vector_rf_write_arbiter_pkg: shared types for the vector RF write arbiter
package vector_rf_write_arbiter_pkg;
  localparam int THREADS = 4;
  localparam int WORD_W = 32;
  localparam int REG_BITS = 5;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_BITS-1:0] regbits_t;
  typedef enum logic {ARB, LOCKED} arb_state_t;
  typedef struct packed {
    regbits_t wsel;
    logic [THREADS-1:0] mask;
    word_t [THREADS-1:0] wdata;
  } vrf_wb_req_t;
endpackage

// File: rtl/vector_rf_write_arbiter_if.sv
// vector_rf_write_arbiter_if: requester, register-file and probe signals of the write arbiter
interface vector_rf_write_arbiter_if #(parameter int NREQ = 2);
  import vector_rf_write_arbiter_pkg::*;
  localparam int OW = $clog2(NREQ);
  logic freeze;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_lock;
  logic [NREQ-1:0] req_ready;
  vrf_wb_req_t [NREQ-1:0] req;
  logic [THREADS-1:0] rf_wen;
  regbits_t rf_wsel;
  word_t [THREADS-1:0] rf_wdata;
  regbits_t chk_sel;
  logic chk_pending;
  logic [OW-1:0] owner;
  modport master(output freeze, req_valid, req_lock, req, chk_sel,
                 input req_ready, rf_wen, rf_wsel, rf_wdata, chk_pending, owner);
  modport slave(input freeze, req_valid, req_lock, req, chk_sel,
                output req_ready, rf_wen, rf_wsel, rf_wdata, chk_pending, owner);
endinterface

// File: rtl/vector_rf_write_arbiter_rr_priority_picker.sv
// vector_rf_write_arbiter_rr_priority_picker: one-hot pick of first valid at or after ptr, with wrap
module vector_rf_write_arbiter_rr_priority_picker #(
  parameter int NREQ = 2,
  parameter int PW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   idx,
  output logic            any
);
  logic [PW-1:0] j;
  always_comb begin
    grant = '0;
    idx = '0;
    any = 1'b0;
    j = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = PW'((int'(ptr) + k) % NREQ);
      if (!any && valid[j]) begin
        any = 1'b1;
        grant[j] = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/vector_rf_write_arbiter.sv
// vector_rf_write_arbiter: round-robin, burst-lockable arbiter feeding a registered RF write stage
module vector_rf_write_arbiter
  import vector_rf_write_arbiter_pkg::*;
#(
  parameter int NREQ = 2
) (
  input logic clk,
  input logic rst_n,
  vector_rf_write_arbiter_if.slave bus
);
  localparam int PW = $clog2(NREQ);
  arb_state_t state;
  logic [PW-1:0] rr_ptr, own, g, pick_idx, nxt;
  logic [NREQ-1:0] pick_grant;
  logic pick_any, go;
  vector_rf_write_arbiter_rr_priority_picker #(.NREQ(NREQ), .PW(PW)) u_pick (
    .valid(bus.req_valid),
    .ptr(rr_ptr),
    .grant(pick_grant),
    .idx(pick_idx),
    .any(pick_any)
  );
  // ready is held low while reset is asserted so nothing is accepted into a cleared stage
  always_comb begin
    g = state == LOCKED ? own : pick_idx;
    go = rst_n && !bus.freeze && (state == LOCKED ? bus.req_valid[own] : pick_any);
    nxt = g == PW'(NREQ - 1) ? '0 : g + 1'b1;
  end
  assign bus.req_ready = go ? (state == LOCKED ? NREQ'(1) << own : pick_grant) : '0;
  assign bus.owner = own;
  assign bus.chk_pending = (|bus.rf_wen) && (bus.rf_wsel == bus.chk_sel);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB;
      rr_ptr <= '0;
      own <= '0;
      bus.rf_wen <= '0;
      bus.rf_wsel <= '0;
      bus.rf_wdata <= '0;
    end else begin
      bus.rf_wen <= go ? bus.req[g].mask : '0;
      if (go) begin
        bus.rf_wsel <= bus.req[g].wsel;
        bus.rf_wdata <= bus.req[g].wdata;
        rr_ptr <= nxt;
        own <= g;
        state <= bus.req_lock[g] ? LOCKED : ARB;
      end
    end
  end
endmodule

// File: doc/vector_rf_write_arbiter.md
Name: vector_rf_write_arbiter

Overview:
- Shares the single write port of the vector register file between NREQ writeback requesters, e.g. the vector ALU pipe and the load/memory pipe.
- Round-robin arbitration with optional burst lock, a registered write stage (1-cycle latency) and a pending-write probe for hazard logic.
- Sits between the writeback stages and the vector register file write inputs (wen/wsel/wdata per thread).

Parameters:
- THREADS, 4, lanes per vector register; width of per-thread wen/wdata arrays.
- NREQ, 2, number of writeback requesters (≥2); index 0 wins the reset-time tie.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- freeze  input  1  when 1, no new grants (pipeline drain or reconfiguration).
- req_valid[NREQ]  input  1  requester i has a write beat.
- req_lock[NREQ]  input  1  requester i keeps ownership after this beat.
- req_wsel[NREQ]  input  regbits_t  destination vector register.
- req_mask[NREQ][THREADS]  input  1  per-thread write enable.
- req_wdata[NREQ][THREADS]  input  word_t  per-thread data.
- req_ready[NREQ]  output  1  beat from i accepted this cycle (combinational grant).
- rf_wen[THREADS]  output  1  to register file wen.
- rf_wsel  output  regbits_t  to register file wsel.
- rf_wdata[THREADS]  output  word_t  to register file wdata.
- chk_sel  input  regbits_t  register probed by hazard logic.
- chk_pending  output  1  registered stage holds a write to chk_sel with a nonzero mask.
- owner  output  $clog2(NREQ)  current lock owner (valid only in LOCKED).

Behaviour:
- Reset (async, nRST=0): state ARB, rr_ptr=0, stage empty, rf_wen all 0, rf_wsel 0, rf_wdata 0, owner 0, req_ready all 0.
- Stage always drains: the register file accepts every cycle, so a grant is possible every cycle without backpressure.
- ARB state:
  - With freeze=0, grant the first valid requester at or after rr_ptr, searching upward with wrap.
  - req_ready[g]=1 the same cycle; every other ready is 0.
  - On grant: rr_ptr←(g+1) mod NREQ. If req_lock[g]=1, go to LOCKED with owner=g.
- LOCKED state:
  - Only owner may be granted; other requesters see ready=0 even when valid.
  - Owner valid with lock=1: grant and stay LOCKED.
  - Owner valid with lock=0: grant the final beat, return to ARB, rr_ptr←owner+1.
  - Owner valid=0: hold LOCKED, no grant (bubble).
- freeze=1: all ready=0, state and rr_ptr unchanged, stage loads a bubble. Freeze overrides LOCKED without releasing the lock.
- Write stage:
  - On grant, the next edge loads rf_wen←req_mask[g], rf_wsel←req_wsel[g], rf_wdata←req_wdata[g].
  - No grant: rf_wen←0; rf_wsel and rf_wdata hold their previous values.
  - Latency is exactly 1 cycle from the accept edge to rf inputs; the RF writes on the following edge.
- All-zero mask: accepted normally, consumes the slot, produces rf_wen all 0, chk_pending 0.
- wsel 0 gets no special treatment; zero-register semantics belong to the register file.
- chk_pending = (|rf_wen) && (rf_wsel==chk_sel). Purely combinational from the stage; does not look at in-flight requests.
- Two requesters targeting the same wsel in consecutive grants are written in grant order; no merging.
- Reset asserted mid-burst: lock abandoned, stage cleared immediately (async). The requester must resend after reset.
- Any req_lock outside an accepted beat is ignored.

Decomposition:
- cpu_types_pkg gains arb_state_t enum {ARB, LOCKED} and vrf_wb_req_t struct {wsel, mask[THREADS], wdata[THREADS]}, parameterised via a THREADS constant already in the package.
- One sub-module: rr_priority_picker (NREQ-wide, rotating-priority one-hot select from valid vector and pointer, combinational). Reused by future memory arbiters.
- The top module drives a vector_register_file_if via its tb modport.

Test Plan:
- Reset then idle: all outputs 0, req_ready 0. Assert req_valid[0], wsel=5, mask=1111, data={1,2,3,4} -> ready[0]=1 same cycle; next cycle rf_wen=1111, rf_wsel=5, rf_wdata={1,2,3,4}; chk_sel=5 gives chk_pending=1.
- Both valid continuously, no lock, NREQ=2 -> grants alternate 0,1,0,1; rf_wsel alternates between the two requesters' values; no starvation over 8 cycles.
- Req1 locks for 3 beats (lock=1,1,0) while req0 is valid -> ready[1] for 3 consecutive cycles, ready[0]=0 throughout, then req0 granted on cycle 4; owner=1 during the lock.
- Owner drops valid for 2 cycles while locked, req0 valid -> 2 bubble cycles (rf_wen=0), req0 still blocked; lock resumes when the owner returns.
- freeze=1 for 3 cycles with both valid -> no ready, rf_wen=0, rr_ptr unchanged; after release the grant goes to the same requester as before freeze.
- Assert nRST=0 mid-burst asynchronously (between edges) -> rf_wen immediately 0, state ARB; mask=0000 beat after reset -> ready=1, rf_wen stays 0, chk_pending=0.
